// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared sizes, FSM states and kernel/bias tables for conv
package conv_pkg;
   localparam int DEF_IMG_W = 32;
   localparam int DEF_IMG_H = 32;
   localparam int DEF_KSIZE = 5;
   localparam int NUM_MAPS  = 6;
   localparam int NUM_TAPS  = DEF_KSIZE * DEF_KSIZE;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FILL = 3'd1,
      S_MACC = 3'd2,
      S_EMIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Q1.7 weights, row-major taps; map 0 is the flat calibration kernel
   localparam logic signed [7:0] WEIGHTS [NUM_MAPS][NUM_TAPS] = '{
      '{default: 8'sd16},
      '{-8'sd8, -8'sd4, 8'sd0, 8'sd4, 8'sd8,  -8'sd8, -8'sd4, 8'sd0, 8'sd4, 8'sd8,
        -8'sd8, -8'sd4, 8'sd0, 8'sd4, 8'sd8,  -8'sd8, -8'sd4, 8'sd0, 8'sd4, 8'sd8,
        -8'sd8, -8'sd4, 8'sd0, 8'sd4, 8'sd8},
      '{-8'sd8, -8'sd8, -8'sd8, -8'sd8, -8'sd8,  -8'sd4, -8'sd4, -8'sd4, -8'sd4, -8'sd4,
        8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0,       8'sd4, 8'sd4, 8'sd4, 8'sd4, 8'sd4,
        8'sd8, 8'sd8, 8'sd8, 8'sd8, 8'sd8},
      '{8'sd2, 8'sd2, 8'sd2, 8'sd2, 8'sd2,  8'sd2, 8'sd2, 8'sd2, 8'sd2, 8'sd2,
        8'sd2, 8'sd2, 8'sd64, 8'sd2, 8'sd2, 8'sd2, 8'sd2, 8'sd2, 8'sd2, 8'sd2,
        8'sd2, 8'sd2, 8'sd2, 8'sd2, 8'sd2},
      '{8'sh80, 8'sd127, -8'sd100, 8'sd90, -8'sd80,  8'sd70, -8'sd60, 8'sd50, -8'sd40, 8'sd30,
        -8'sd20, 8'sd10, 8'sd0, -8'sd10, 8'sd20,     -8'sd30, 8'sd40, -8'sd50, 8'sd60, -8'sd70,
        8'sd80, -8'sd90, 8'sd100, -8'sd127, 8'sd127},
      '{8'sd32, -8'sd32, 8'sd32, -8'sd32, 8'sd32,  -8'sd32, 8'sd32, -8'sd32, 8'sd32, -8'sd32,
        8'sd32, -8'sd32, 8'sd32, -8'sd32, 8'sd32,  -8'sd32, 8'sd32, -8'sd32, 8'sd32, -8'sd32,
        8'sd32, -8'sd32, 8'sd32, -8'sd32, 8'sd32}
   };

   localparam logic signed [7:0] BIAS [NUM_MAPS] = '{
      8'sd0, 8'sd5, -8'sd7, 8'sd127, 8'sh80, 8'sd1
   };
endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - four row delay lines feeding a KSIZE x KSIZE sliding window
module conv_line_buffer #(
   parameter int IMG_W = 32,
   parameter int KSIZE = 5,
   parameter int AW    = $clog2(IMG_W)
) (
   input  logic          clk_i,
   input  logic          shift_i,
   input  logic [7:0]    pix_i,
   input  logic [AW-1:0] col_i,
   output logic [7:0]    win_o [KSIZE*KSIZE]
);
   logic [7:0] line_q [KSIZE-1][IMG_W];
   logic [7:0] win_q  [KSIZE][KSIZE];

   always_ff @(posedge clk_i) begin
      if (shift_i) begin
         for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE-1; c++) begin
               win_q[r][c] <= win_q[r][c+1];
            end
         end
         // line KSIZE-2 holds the oldest row, so it feeds the top of the window
         for (int r = 0; r < KSIZE-1; r++) begin
            win_q[r][KSIZE-1] <= line_q[KSIZE-2-r][col_i];
         end
         win_q[KSIZE-1][KSIZE-1] <= pix_i;
         line_q[0][col_i] <= pix_i;
         for (int l = 1; l < KSIZE-1; l++) begin
            line_q[l][col_i] <= line_q[l-1][col_i];
         end
      end
   end

   always_comb begin
      for (int r = 0; r < KSIZE; r++) begin
         for (int c = 0; c < KSIZE; c++) begin
            win_o[r*KSIZE+c] = win_q[r][c];
         end
      end
   end
endmodule

// File: rtl/conv.sv
// rtl/conv.sv - streaming 5x5 convolution producing six feature maps per window
module conv
   import conv_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int KSIZE = DEF_KSIZE
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_feature_valid,
   input  logic [7:0]         i_feature,
   output logic               o_ready_feature,
   output logic               o_feature_valid,
   output logic signed [15:0] o_features [0:NUM_MAPS-1],
   output logic               o_last_feature,
   output logic [10:0]        debug_conv_col,
   output logic [10:0]        debug_conv_row,
   output logic [2:0]         debug_state,
   output logic               debug_macc_en
);
   localparam int AW   = $clog2(IMG_W);
   localparam int TAPS = KSIZE * KSIZE;
   localparam int TW   = $clog2(TAPS);
   localparam logic [10:0]   COL_LAST = 11'(IMG_W - 1);
   localparam logic [10:0]   ROW_LAST = 11'(IMG_H - 1);
   localparam logic [10:0]   WIN_MIN  = 11'(KSIZE - 1);
   localparam logic [TW-1:0] TAP_LAST = TW'(TAPS - 1);

   state_t             state_q;
   logic [10:0]        col_q, row_q;
   logic [TW-1:0]      tap_q;
   logic               ready_q, valid_q, last_q, macc_en_q, frame_end_q;
   logic signed [23:0] acc_q  [NUM_MAPS];
   logic signed [15:0] feat_q [NUM_MAPS];

   logic [7:0]         win [TAPS];
   logic               accept, win_done;
   logic [16:0]        pix_ext, w_ext;
   logic signed [16:0] prod    [NUM_MAPS];
   logic signed [23:0] acc_d   [NUM_MAPS];
   logic signed [23:0] shifted [NUM_MAPS];
   logic signed [15:0] res_d   [NUM_MAPS];

   conv_line_buffer #(.IMG_W(IMG_W), .KSIZE(KSIZE), .AW(AW)) u_lb (
      .clk_i   (i_clk),
      .shift_i (accept),
      .pix_i   (i_feature),
      .col_i   (col_q[AW-1:0]),
      .win_o   (win)
   );

   always_comb begin
      accept   = i_feature_valid && ready_q;
      win_done = accept && (row_q >= WIN_MIN) && (col_q >= WIN_MIN);
      pix_ext  = {9'd0, win[tap_q]};
      w_ext    = '0;
      for (int m = 0; m < NUM_MAPS; m++) begin
         w_ext      = {{9{WEIGHTS[m][tap_q][7]}}, WEIGHTS[m][tap_q]};
         prod[m]    = $signed(pix_ext) * $signed(w_ext);
         acc_d[m]   = acc_q[m] + {{7{prod[m][16]}}, prod[m]};
         shifted[m] = acc_d[m] >>> 7;
         res_d[m]   = shifted[m][15:0] + {{8{BIAS[m][7]}}, BIAS[m]};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         tap_q       <= '0;
         ready_q     <= 1'b0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         macc_en_q   <= 1'b0;
         frame_end_q <= 1'b0;
         for (int m = 0; m < NUM_MAPS; m++) begin
            acc_q[m]  <= '0;
            feat_q[m] <= '0;
         end
      end else begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               state_q <= S_FILL;
               ready_q <= 1'b1;
            end
            S_FILL: begin
               if (accept) begin
                  if (col_q == COL_LAST) begin
                     col_q <= '0;
                     row_q <= (row_q == ROW_LAST) ? '0 : row_q + 11'd1;
                  end else begin
                     col_q <= col_q + 11'd1;
                  end
                  if (win_done) begin
                     state_q     <= S_MACC;
                     ready_q     <= 1'b0;
                     macc_en_q   <= 1'b1;
                     tap_q       <= '0;
                     frame_end_q <= (row_q == ROW_LAST) && (col_q == COL_LAST);
                     for (int m = 0; m < NUM_MAPS; m++) acc_q[m] <= '0;
                  end
               end
            end
            S_MACC: begin
               for (int m = 0; m < NUM_MAPS; m++) acc_q[m] <= acc_d[m];
               tap_q <= tap_q + TW'(1);
               if (tap_q == TAP_LAST) begin
                  state_q   <= S_EMIT;
                  tap_q     <= '0;
                  macc_en_q <= 1'b0;
                  valid_q   <= 1'b1;
                  last_q    <= frame_end_q;
                  for (int m = 0; m < NUM_MAPS; m++) feat_q[m] <= res_d[m];
               end
            end
            S_EMIT: begin
               if (frame_end_q) begin
                  state_q <= S_DONE;
               end else begin
                  state_q <= S_FILL;
                  ready_q <= 1'b1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_ready_feature = ready_q;
   assign o_feature_valid = valid_q;
   assign o_last_feature  = last_q;
   assign o_features      = feat_q;
   assign debug_conv_col  = col_q;
   assign debug_conv_row  = row_q;
   assign debug_state     = state_q;
   assign debug_macc_en   = macc_en_q;
endmodule

// File: tb/tb_conv.sv
// tb/tb_conv.sv - randomized self-checking bench for conv against a direct-convolution model
module tb_conv;
   import conv_pkg::*;

   localparam int W    = 32;
   localparam int H    = 32;
   localparam int K    = 5;
   localparam int NR   = W - K + 1;
   localparam int NRES = NR * (H - K + 1);

   logic               i_clk = 1'b0;
   logic               i_rst = 1'b1;
   logic               i_feature_valid = 1'b0;
   logic [7:0]         i_feature = 8'd0;
   logic               o_ready_feature, o_feature_valid, o_last_feature, debug_macc_en;
   logic signed [15:0] o_features [0:NUM_MAPS-1];
   logic [10:0]        debug_conv_col, debug_conv_row;
   logic [2:0]         debug_state;

   conv dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_feature_valid (i_feature_valid),
      .i_feature       (i_feature),
      .o_ready_feature (o_ready_feature),
      .o_feature_valid (o_feature_valid),
      .o_features      (o_features),
      .o_last_feature  (o_last_feature),
      .debug_conv_col  (debug_conv_col),
      .debug_conv_row  (debug_conv_row),
      .debug_state     (debug_state),
      .debug_macc_en   (debug_macc_en)
   );

   always #5 i_clk = ~i_clk;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [7:0]  img [H][W];
   int          acc_id [H*W];
   logic [95:0] got_f [$];
   bit          got_last [$];
   int          got_cyc [$];
   logic [95:0] ref_f [$];
   logic [95:0] mon_v;

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (!i_rst && o_feature_valid) begin
         for (int m = 0; m < NUM_MAPS; m++) mon_v[m*16 +: 16] = o_features[m];
         got_f.push_back(mon_v);
         got_last.push_back(o_last_feature);
         got_cyc.push_back(cyc + 1);
      end
   end

   function automatic logic [95:0] model(input int r, input int c);
      logic [95:0] e;
      int s, v;
      e = '0;
      for (int m = 0; m < NUM_MAPS; m++) begin
         s = 0;
         for (int kr = 0; kr < K; kr++)
            for (int kc = 0; kc < K; kc++)
               s += int'(img[r-K+1+kr][c-K+1+kc]) * int'(WEIGHTS[m][kr*K+kc]);
         v = (s >>> 7) + int'(BIAS[m]);
         e[m*16 +: 16] = v[15:0];
      end
      return e;
   endfunction

   function automatic logic [95:0] cur_features();
      logic [95:0] v;
      for (int m = 0; m < NUM_MAPS; m++) v[m*16 +: 16] = o_features[m];
      return v;
   endfunction

   task automatic clear_results();
      got_f.delete();
      got_last.delete();
      got_cyc.delete();
   endtask

   task automatic drive(input int n, input bit toggle, output int cnt_err, output int timeout);
      int idx = 0;
      int budget = n * 40 + 200;
      cnt_err = 0;
      timeout = 0;
      while (idx < n) begin
         @(negedge i_clk);
         if (budget == 0) begin
            timeout = 1;
            break;
         end
         budget--;
         if (debug_conv_col !== 11'(idx % W) || debug_conv_row !== 11'((idx / W) % H)) cnt_err++;
         i_feature_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         i_feature = img[(idx / W) % H][idx % W];
         if (i_feature_valid && o_ready_feature) begin
            acc_id[idx] = cyc + 1;
            idx++;
         end
      end
      @(posedge i_clk);
      #1;
      i_feature_valid = 1'b0;
   endtask

   task automatic wait_results(input int n);
      for (int i = 0; i < 200 && got_f.size() < n; i++) @(negedge i_clk);
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      i_feature_valid = 1'b1;
      i_feature = 8'd7;
      #20;
      #1;
      checks++; if (debug_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", debug_state); end
      checks++; if ({o_ready_feature, o_feature_valid, o_last_feature, debug_macc_en} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {o_ready_feature, o_feature_valid, o_last_feature, debug_macc_en}); end
      checks++; if ({debug_conv_row, debug_conv_col} !== 22'd0) begin failures++; $display("FAIL reset_counters got row=%0d col=%0d exp 0/0", debug_conv_row, debug_conv_col); end
      checks++; if (cur_features() !== 96'd0) begin failures++; $display("FAIL reset_features got=%h exp=0", cur_features()); end
      i_rst = 1'b0;
      #1;
      checks++; if (debug_state !== 3'd0 || o_ready_feature !== 1'b0) begin failures++; $display("FAIL idle_after_release got state=%0d ready=%b exp 0/0", debug_state, o_ready_feature); end
      @(negedge i_clk);
      checks++; if (debug_state !== 3'd1 || o_ready_feature !== 1'b1) begin failures++; $display("FAIL fill_after_idle got state=%0d ready=%b exp 1/1", debug_state, o_ready_feature); end
      checks++; if (debug_conv_col !== 11'd0) begin failures++; $display("FAIL no_accept_in_idle got col=%0d exp 0", debug_conv_col); end
      @(negedge i_clk);
      checks++; if (debug_conv_col !== 11'd1) begin failures++; $display("FAIL first_accept got col=%0d exp 1", debug_conv_col); end
      i_feature_valid = 1'b0;
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_constant_frame();
      int ce, to, nlast;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'd40;
      clear_results();
      drive(W*H, 1'b0, ce, to);
      wait_results(NRES);
      checks++; if (to !== 0) begin failures++; $display("FAIL const_drive_timeout got=%0d exp=0", to); end
      checks++; if (got_f.size() !== NRES) begin failures++; $display("FAIL const_result_count got=%0d exp=%0d", got_f.size(), NRES); end
      nlast = 0;
      for (int i = 0; i < got_f.size(); i++) begin
         checks++; if (got_f[i][15:0] !== 16'd125) begin failures++; $display("FAIL const_map0 idx=%0d got=%0d exp=125", i, $signed(got_f[i][15:0])); end
         checks++; if (got_last[i] !== (i == NRES-1)) begin failures++; $display("FAIL const_last idx=%0d got=%b exp=%b", i, got_last[i], i == NRES-1); end
      end
      if (got_f.size() > 0) begin
         checks++; if (got_cyc[0] - acc_id[4*W+4] !== 26) begin failures++; $display("FAIL first_latency got=%0d exp=26", got_cyc[0] - acc_id[4*W+4]); end
      end
      checks++; if (acc_id[4*W+5] - acc_id[4*W+4] - 1 !== 26) begin failures++; $display("FAIL ready_low_first got=%0d exp=26", acc_id[4*W+5] - acc_id[4*W+4] - 1); end
      checks++; if (acc_id[20*W+11] - acc_id[20*W+10] - 1 !== 26) begin failures++; $display("FAIL ready_low_mid got=%0d exp=26", acc_id[20*W+11] - acc_id[20*W+10] - 1); end
      checks++; if (acc_id[4*W+3] - acc_id[4*W+2] !== 1) begin failures++; $display("FAIL no_stall_col_lt4 got=%0d exp=1", acc_id[4*W+3] - acc_id[4*W+2]); end
   endtask

   task automatic test_reset_during_macc();
      int ce, to, waited;
      logic [95:0] exp_v;
      void'($urandom(1234));
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(0, 255));
      clear_results();
      drive(140, 1'b0, ce, to);
      waited = 0;
      while (!debug_macc_en && waited < 60) begin
         @(negedge i_clk);
         waited++;
      end
      repeat (5) @(negedge i_clk);
      checks++; if (debug_macc_en !== 1'b1) begin failures++; $display("FAIL abort_in_macc got=%b exp=1", debug_macc_en); end
      checks++; if (got_f.size() !== 7) begin failures++; $display("FAIL abort_results_before got=%0d exp=7", got_f.size()); end
      exp_v = model(4, 10);
      checks++; if (cur_features() !== exp_v) begin failures++; $display("FAIL features_hold got=%h exp=%h", cur_features(), exp_v); end
      #2;
      i_rst = 1'b1;
      #1;
      checks++; if (cur_features() !== 96'd0) begin failures++; $display("FAIL abort_features got=%h exp=0", cur_features()); end
      checks++; if ({debug_state, debug_macc_en, o_ready_feature, o_feature_valid, o_last_feature} !== 7'd0) begin failures++; $display("FAIL abort_flags got state=%0d macc=%b ready=%b valid=%b last=%b exp all 0", debug_state, debug_macc_en, o_ready_feature, o_feature_valid, o_last_feature); end
      checks++; if ({debug_conv_row, debug_conv_col} !== 22'd0) begin failures++; $display("FAIL abort_counters got row=%0d col=%0d exp 0/0", debug_conv_row, debug_conv_col); end
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_random_frame();
      int ce, to;
      logic [95:0] exp_v;
      clear_results();
      drive(W*H, 1'b0, ce, to);
      wait_results(NRES);
      checks++; if (to !== 0) begin failures++; $display("FAIL rand_drive_timeout got=%0d exp=0", to); end
      checks++; if (got_f.size() !== NRES) begin failures++; $display("FAIL rand_result_count got=%0d exp=%0d", got_f.size(), NRES); end
      for (int i = 0; i < got_f.size() && i < NRES; i++) begin
         exp_v = model(K-1 + i / NR, K-1 + i % NR);
         checks++; if (got_f[i] !== exp_v) begin failures++; $display("FAIL rand_window r=%0d c=%0d got=%h exp=%h", K-1 + i / NR, K-1 + i % NR, got_f[i], exp_v); end
      end
      ref_f = got_f;
   endtask

   task automatic test_toggle_valid();
      int ce, to;
      logic [95:0] exp_v;
      clear_results();
      drive(W*H, 1'b1, ce, to);
      wait_results(NRES);
      repeat (4) @(negedge i_clk);
      checks++; if (to !== 0) begin failures++; $display("FAIL toggle_drive_timeout got=%0d exp=0", to); end
      checks++; if (ce !== 0) begin failures++; $display("FAIL toggle_counter_track got=%0d errors exp=0", ce); end
      checks++; if (got_f.size() !== NRES) begin failures++; $display("FAIL toggle_result_count got=%0d exp=%0d", got_f.size(), NRES); end
      checks++; if ({debug_conv_row, debug_conv_col} !== 22'd0) begin failures++; $display("FAIL toggle_counter_wrap got row=%0d col=%0d exp 0/0", debug_conv_row, debug_conv_col); end
      for (int i = 0; i < got_f.size() && i < NRES; i++) begin
         exp_v = model(K-1 + i / NR, K-1 + i % NR);
         checks++; if (got_f[i] !== exp_v) begin failures++; $display("FAIL toggle_window idx=%0d got=%h exp=%h", i, got_f[i], exp_v); end
         if (i < ref_f.size()) begin
            checks++; if (got_f[i] !== ref_f[i]) begin failures++; $display("FAIL toggle_vs_continuous idx=%0d got=%h exp=%h", i, got_f[i], ref_f[i]); end
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_constant_frame();
      test_reset_during_macc();
      test_random_frame();
      test_toggle_valid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
